// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS CPU: sequences the shared ALU,
// unified memory and PC path, with a ready-based memory wait and timeout abort.
module multi_cycle_ctrl #(
    parameter int unsigned STATE_W  = 4,
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned WCNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [2:0]         ALU_op_o,
    output logic               instr_done_o,
    output logic               illegal_o,
    output logic               timeout_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, WB_LW, MEMWR, EXEC_R,
        WB_R, EXEC_I, WB_I, BEQ, JUMP, ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t            state_q, state_d;
    logic [5:0]        op_q;
    logic [WCNT_W-1:0] wait_cnt;
    logic              is_mem;
    logic              timeout;
    logic [2:0]        imm_alu_op;

    assign is_mem     = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout    = (WAIT_MAX != 0) && is_mem && !mem_ready_i &&
                        (wait_cnt == WCNT_W'(WAIT_MAX));
    assign imm_alu_op = (op_q == OP_SLTI) ? 3'b011 : 3'b010;
    assign state_o    = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= instr_op_i;
            // A FETCH timeout stays in FETCH, so clear on timeout as well as on a move.
            if (state_d != state_q || timeout)
                wait_cnt <= '0;
            else if (is_mem && !mem_ready_i)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                case (instr_op_i)
                    OP_RTYPE:        state_d = EXEC_R;
                    OP_ADDI, OP_SLTI: state_d = EXEC_I;
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_BEQ:          state_d = BEQ;
                    OP_J:            state_d = JUMP;
                    default:         state_d = ILLEGAL;
                endcase
            end
            MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready_i) state_d = WB_LW;
                     else if (timeout) state_d = FETCH;
            MEMWR:   if (mem_ready_i || timeout) state_d = FETCH;
            EXEC_R:  state_d = WB_R;
            EXEC_I:  state_d = WB_I;
            WB_LW, WB_R, WB_I, BEQ, JUMP, ILLEGAL: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        ALU_op_o      = 3'b000;
        instr_done_o  = 1'b0;
        illegal_o     = 1'b0;
        timeout_o     = timeout;
        case (state_q)
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALU_op_o  = 3'b010;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            DECODE: begin
                ALUSrcB_o = 2'b11;
                ALU_op_o  = 3'b010;
            end
            MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = 3'b010;
            end
            MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            WB_LW: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            MEMWR: begin
                MemWrite_o   = 1'b1;
                IorD_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            EXEC_R: ALUSrcA_o = 1'b1;
            WB_R: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = imm_alu_op;
            end
            WB_I: begin
                RegWrite_o   = 1'b1;
                ALUSrcA_o    = 1'b1;
                ALUSrcB_o    = 2'b10;
                ALU_op_o     = imm_alu_op;
                instr_done_o = 1'b1;
            end
            BEQ: begin
                ALUSrcA_o     = 1'b1;
                ALU_op_o      = 3'b100;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                instr_done_o  = 1'b1;
            end
            JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                instr_done_o = 1'b1;
            end
            ILLEGAL: illegal_o = 1'b1;
            default: ;
        endcase
        if (timeout) begin
            PCWrite_o  = 1'b0;
            IRWrite_o  = 1'b0;
            MemWrite_o = 1'b0;
            RegWrite_o = 1'b0;
        end
        // Outputs are combinational from state, so reset must mask them directly.
        if (!rst_i) begin
            {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
             MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
             ALU_op_o, instr_done_o, illegal_o, timeout_o} = '0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus queues hand-written per-cycle
// output vectors, a negedge monitor pops and compares them against the DUT.
module tb_multi_cycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
    logic [1:0] ALUSrcB_o, PCSource_o;
    logic [2:0] ALU_op_o;
    logic       instr_done_o, illegal_o, timeout_o;
    logic [3:0] state_o;

    multi_cycle_ctrl #(.STATE_W(4), .WAIT_MAX(4), .WCNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
        .ALU_op_o(ALU_op_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
        .timeout_o(timeout_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    logic [23:0] obs;
    assign obs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                  MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
                  ALU_op_o, instr_done_o, illegal_o, timeout_o, state_o};

    // Argument order: pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb pcsrc aluop done ill to state
    function automatic logic [23:0] mk(
        int unsigned pcw, int unsigned pcwc, int unsigned iord, int unsigned mrd,
        int unsigned mwr, int unsigned irw, int unsigned m2r, int unsigned rdst,
        int unsigned rw, int unsigned srca, int unsigned srcb, int unsigned pcsrc,
        int unsigned aluop, int unsigned done, int unsigned ill, int unsigned to,
        int unsigned st);
        return {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], m2r[0], rdst[0],
                rw[0], srca[0], srcb[1:0], pcsrc[1:0], aluop[2:0], done[0], ill[0],
                to[0], st[3:0]};
    endfunction

    localparam logic [23:0] RST    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    localparam logic [23:0] F_W    = mk(0,0,0,1,0,0,0,0,0,0,1,0,2,0,0,0,0);
    localparam logic [23:0] F_R    = mk(1,0,0,1,0,1,0,0,0,0,1,0,2,0,0,0,0);
    localparam logic [23:0] F_TO   = mk(0,0,0,1,0,0,0,0,0,0,1,0,2,0,0,1,0);
    localparam logic [23:0] DEC    = mk(0,0,0,0,0,0,0,0,0,0,3,0,2,0,0,0,1);
    localparam logic [23:0] MADR   = mk(0,0,0,0,0,0,0,0,0,1,2,0,2,0,0,0,2);
    localparam logic [23:0] MRD    = mk(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,3);
    localparam logic [23:0] MRD_TO = mk(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1,3);
    localparam logic [23:0] WBLW   = mk(0,0,0,0,0,0,1,0,1,0,0,0,0,1,0,0,4);
    localparam logic [23:0] MWR_W  = mk(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,5);
    localparam logic [23:0] MWR_R  = mk(0,0,1,0,1,0,0,0,0,0,0,0,0,1,0,0,5);
    localparam logic [23:0] MWR_TO = mk(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1,5);
    localparam logic [23:0] EXR    = mk(0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,6);
    localparam logic [23:0] WBR    = mk(0,0,0,0,0,0,0,1,1,0,0,0,0,1,0,0,7);
    localparam logic [23:0] EXI_A  = mk(0,0,0,0,0,0,0,0,0,1,2,0,2,0,0,0,8);
    localparam logic [23:0] EXI_S  = mk(0,0,0,0,0,0,0,0,0,1,2,0,3,0,0,0,8);
    localparam logic [23:0] WBI_A  = mk(0,0,0,0,0,0,0,0,1,1,2,0,2,1,0,0,9);
    localparam logic [23:0] WBI_S  = mk(0,0,0,0,0,0,0,0,1,1,2,0,3,1,0,0,9);
    localparam logic [23:0] BEQS   = mk(0,1,0,0,0,0,0,0,0,1,0,1,4,1,0,0,10);
    localparam logic [23:0] JMP    = mk(1,0,0,0,0,0,0,0,0,0,0,2,0,1,0,0,11);
    localparam logic [23:0] ILL    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,12);

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

    typedef struct {
        logic [23:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always @(negedge clk_i) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL %s: got %h expected %h (state %0d)", e.nm, obs, e.v, state_o);
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic rdy, input logic [23:0] e,
                        input string nm);
        instr_op_i  = op;
        mem_ready_i = rdy;
        q.push_back('{v: e, nm: nm});
        @(posedge clk_i);
        #1;
    endtask

    task automatic quick(input logic [5:0] op, input logic [23:0] last, input string nm);
        step(op, 1'b1, F_R, {nm, "_fetch"});
        step(op, 1'b1, DEC, {nm, "_decode"});
        step(op, 1'b1, last, {nm, "_exec"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b0;
        instr_op_i  = '0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        step(OP_R, 1'b0, RST, "reset_hold0");
        step(OP_LW, 1'b1, RST, "reset_hold1");
        rst_i = 1'b1;

        // addi: 0,1,8,9
        step(OP_ADDI, 1'b1, F_R, "addi_fetch");
        step(OP_ADDI, 1'b1, DEC, "addi_decode");
        step(OP_ADDI, 1'b1, EXI_A, "addi_exec");
        step(OP_ADDI, 1'b1, WBI_A, "addi_wb");

        // lw with 2 FETCH stalls and 3 MEMRD stalls: 10 cycles
        step(OP_LW, 1'b0, F_W, "lw_fstall0");
        step(OP_LW, 1'b0, F_W, "lw_fstall1");
        step(OP_LW, 1'b1, F_R, "lw_fetch");
        step(OP_LW, 1'b1, DEC, "lw_decode");
        step(OP_LW, 1'b1, MADR, "lw_memadr");
        for (int unsigned i = 0; i < 3; i++) step(OP_R, 1'b0, MRD, "lw_rdstall");
        step(OP_R, 1'b1, MRD, "lw_memrd");
        step(OP_R, 1'b1, WBLW, "lw_wb");

        quick(OP_BEQ, BEQS, "beq");
        quick(OP_J, JMP, "j");
        quick(OP_BAD, ILL, "illegal");

        step(OP_R, 1'b1, F_R, "rtype_fetch");
        step(OP_R, 1'b1, DEC, "rtype_decode");
        step(OP_R, 1'b1, EXR, "rtype_exec");
        step(OP_R, 1'b1, WBR, "rtype_wb");

        step(OP_SLTI, 1'b1, F_R, "slti_fetch");
        step(OP_SLTI, 1'b1, DEC, "slti_decode");
        step(OP_ADDI, 1'b1, EXI_S, "slti_exec");
        step(OP_ADDI, 1'b1, WBI_S, "slti_wb");

        step(OP_SW, 1'b1, F_R, "sw_fetch");
        step(OP_SW, 1'b1, DEC, "sw_decode");
        step(OP_LW, 1'b1, MADR, "sw_memadr");
        step(OP_LW, 1'b1, MWR_R, "sw_memwr");

        // sw timeout: 4 stalls, abort on the 5th, then back to FETCH
        step(OP_SW, 1'b1, F_R, "swto_fetch");
        step(OP_SW, 1'b1, DEC, "swto_decode");
        step(OP_SW, 1'b1, MADR, "swto_memadr");
        for (int unsigned i = 0; i < 4; i++) step(OP_SW, 1'b0, MWR_W, "swto_stall");
        step(OP_SW, 1'b0, MWR_TO, "swto_abort");
        step(OP_SW, 1'b0, F_W, "swto_refetch");
        step(OP_J, 1'b1, F_R, "swto_fetch2");
        step(OP_J, 1'b1, DEC, "swto_decode2");
        step(OP_J, 1'b1, JMP, "swto_jump");

        // ready on the limit cycle wins over timeout
        step(OP_LW, 1'b1, F_R, "rdywin_fetch");
        step(OP_LW, 1'b1, DEC, "rdywin_decode");
        step(OP_LW, 1'b1, MADR, "rdywin_memadr");
        for (int unsigned i = 0; i < 4; i++) step(OP_LW, 1'b0, MRD, "rdywin_stall");
        step(OP_LW, 1'b1, MRD, "rdywin_ready");
        step(OP_LW, 1'b1, WBLW, "rdywin_wb");

        // lw abort in MEMRD
        step(OP_LW, 1'b1, F_R, "lwto_fetch");
        step(OP_LW, 1'b1, DEC, "lwto_decode");
        step(OP_LW, 1'b1, MADR, "lwto_memadr");
        for (int unsigned i = 0; i < 4; i++) step(OP_LW, 1'b0, MRD, "lwto_stall");
        step(OP_LW, 1'b0, MRD_TO, "lwto_abort");

        // FETCH timeout refetches and restarts the count
        for (int unsigned i = 0; i < 4; i++) step(OP_R, 1'b0, F_W, "fto_stall");
        step(OP_R, 1'b0, F_TO, "fto_abort1");
        for (int unsigned i = 0; i < 4; i++) step(OP_R, 1'b0, F_W, "fto_restall");
        step(OP_R, 1'b0, F_TO, "fto_abort2");
        step(OP_J, 1'b1, F_R, "fto_fetch");
        step(OP_J, 1'b1, DEC, "fto_decode");
        step(OP_J, 1'b1, JMP, "fto_jump");

        // asynchronous reset in the middle of a MEMWR stall
        step(OP_SW, 1'b1, F_R, "swrst_fetch");
        step(OP_SW, 1'b1, DEC, "swrst_decode");
        step(OP_SW, 1'b1, MADR, "swrst_memadr");
        step(OP_SW, 1'b0, MWR_W, "swrst_stall0");
        instr_op_i  = OP_SW;
        mem_ready_i = 1'b0;
        q.push_back('{v: MWR_W, nm: "swrst_stall1"});
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== RST) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", obs, RST);
        end
        @(posedge clk_i);
        #1;
        step(OP_SW, 1'b0, RST, "swrst_held");
        rst_i = 1'b1;
        for (int unsigned i = 0; i < 4; i++) step(OP_R, 1'b0, F_W, "postrst_stall");
        step(OP_R, 1'b0, F_TO, "postrst_abort");
        quick(OP_ADDI, EXI_A, "postrst_addi");
        step(OP_ADDI, 1'b1, WBI_A, "postrst_addi_wb");

        for (int unsigned i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_i);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
